// File: rtl/anim_sequencer.sv
// -----------------------------------------------------------------------------
// anim_sequencer
//
// Frame-animation player for the screen path. A free-running divider, gated by
// enable/pause/playing, produces one frame tick every 2^DIV_W clk cycles. On
// each tick the sequencer frame index steps according to the play mode. The
// displayed frame (disp_idx) only follows the sequencer frame on vsync, so a
// frame never changes in the middle of a scan. Pixel coordinates are turned
// into a registered linear sprite-ROM address for the displayed frame.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   enable      divider runs while high
//   pause       freezes divider and frame index while high
//   restart     synchronous restart of the sequence (wins over a tick)
//   mode        00 loop, 01 ping-pong, 10 one-shot, 11 reverse loop
//   vsync       frame-boundary strobe; commits frame_idx to disp_idx
//   ram_addr_x  pixel x
//   ram_addr_y  pixel y
//   rom_addr    registered sprite-ROM address (0 when out of range)
//   pix_valid   registered; coordinate was in range
//   frame_idx   sequencer frame
//   disp_idx    frame currently used for addressing
//   playing     sequence active (falls only at the end of a one-shot run)
//   done        one-cycle pulse at sequence completion, aligned with the
//               frame_idx update that completes the sequence
//
// There are no valid/ready handshakes in this block: all inputs are sampled
// every cycle and all outputs are registered.
// -----------------------------------------------------------------------------
module anim_sequencer #(
   parameter int FRAMES = 16,
   parameter int DIV_W  = 24,
   parameter int IMG_W  = 160,
   parameter int IMG_H  = 120,
   parameter int ADDR_W = 19,
   localparam int IDX_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              pause,
   input  logic              restart,
   input  logic [1:0]        mode,
   input  logic              vsync,
   input  logic [7:0]        ram_addr_x,
   input  logic [7:0]        ram_addr_y,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              pix_valid,
   output logic [IDX_W-1:0]  frame_idx,
   output logic [IDX_W-1:0]  disp_idx,
   output logic              playing,
   output logic              done
);

   localparam logic [1:0] MODE_LOOP    = 2'b00;
   localparam logic [1:0] MODE_PING    = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;
   localparam logic [1:0] MODE_REV     = 2'b11;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam logic [IDX_W-1:0]  LAST     = IDX_W'(FRAMES - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(IMG_W * IMG_H);
   localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(IMG_W);

   logic [DIV_W-1:0] div;
   logic             dir;
   logic             run;
   logic             tick;

   logic [IDX_W-1:0] nxt_idx;
   logic             nxt_dir;
   logic             nxt_play;
   logic             nxt_done;

   logic              in_range;
   logic [ADDR_W-1:0] addr_c;

   // The divider only advances while the sequence is live; a finished
   // one-shot therefore produces no further ticks until restart.
   assign run  = enable & ~pause & playing;
   assign tick = run & (&div);

   // Next-state of the sequencer for the tick case. Outside ping-pong the
   // direction is pinned to up every cycle, so re-entering ping-pong always
   // starts by counting upwards.
   always_comb begin
      nxt_idx  = frame_idx;
      nxt_dir  = (mode == MODE_PING) ? dir : DIR_UP;
      nxt_play = playing;
      nxt_done = 1'b0;
      if (tick) begin
         case (mode)
            MODE_LOOP: begin
               if (frame_idx == LAST) begin
                  nxt_idx  = '0;
                  nxt_done = 1'b1;
               end else begin
                  nxt_idx = frame_idx + IDX_ONE;
               end
            end
            MODE_PING: begin
               if (FRAMES == 1) begin
                  nxt_done = 1'b1;
               end else if (dir == DIR_UP && frame_idx != LAST) begin
                  nxt_idx = frame_idx + IDX_ONE;
               end else if (frame_idx == '0) begin
                  // Down at 0 is not reachable in normal play; recover upward.
                  nxt_idx = IDX_ONE;
                  nxt_dir = DIR_UP;
               end else begin
                  // Turning at the top or stepping down. Reaching 0 ends the
                  // round trip; this also covers FRAMES==2 (top is 1).
                  nxt_idx = frame_idx - IDX_ONE;
                  if (frame_idx == IDX_ONE) begin
                     nxt_dir  = DIR_UP;
                     nxt_done = 1'b1;
                  end else begin
                     nxt_dir = DIR_DOWN;
                  end
               end
            end
            MODE_ONESHOT: begin
               if (frame_idx == LAST) begin
                  nxt_play = 1'b0;
                  nxt_done = 1'b1;
               end else begin
                  nxt_idx = frame_idx + IDX_ONE;
               end
            end
            MODE_REV: begin
               if (frame_idx == '0) begin
                  nxt_idx  = LAST;
                  nxt_done = 1'b1;
               end else begin
                  nxt_idx = frame_idx - IDX_ONE;
               end
            end
            default: begin
               nxt_idx = frame_idx;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div       <= '0;
         frame_idx <= '0;
         dir       <= DIR_UP;
         playing   <= 1'b1;
         done      <= 1'b0;
      end else if (restart) begin
         div       <= '0;
         dir       <= DIR_UP;
         playing   <= 1'b1;
         done      <= 1'b0;
         frame_idx <= (mode == MODE_REV) ? LAST : '0;
      end else begin
         if (run) begin
            div <= div + 1'b1;
         end
         frame_idx <= nxt_idx;
         dir       <= nxt_dir;
         playing   <= nxt_play;
         done      <= nxt_done;
      end
   end

   // Commit samples frame_idx before this edge's update, so a tick and vsync
   // in the same cycle display the pre-tick frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_idx <= '0;
      end else if (vsync) begin
         disp_idx <= frame_idx;
      end
   end

   assign in_range = (int'(ram_addr_x) < IMG_W) && (int'(ram_addr_y) < IMG_H);
   assign addr_c   = ADDR_W'(disp_idx) * FRAME_SZ
                   + ADDR_W'(ram_addr_y) * ROW_SZ
                   + ADDR_W'(ram_addr_x);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr  <= '0;
         pix_valid <= 1'b0;
      end else if (in_range) begin
         rom_addr  <= addr_c;
         pix_valid <= 1'b1;
      end else begin
         rom_addr  <= '0;
         pix_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_anim_sequencer.sv
// -----------------------------------------------------------------------------
// tb_anim_sequencer
//
// Directed bench for anim_sequencer with FRAMES=4, DIV_W=2 (a tick every 4
// cycles) and a 160x120 frame. Expected frame sequences are held in a queue
// and popped at each tick; all other expectations are hand-computed constants
// or the address formula. Inputs change and outputs are sampled 1 time unit
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_anim_sequencer;

   localparam int FRAMES = 4;
   localparam int DIV_W  = 2;
   localparam int IMG_W  = 160;
   localparam int IMG_H  = 120;
   localparam int ADDR_W = 19;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic              pause;
   logic              restart;
   logic [1:0]        mode;
   logic              vsync;
   logic [7:0]        ram_addr_x;
   logic [7:0]        ram_addr_y;
   logic [ADDR_W-1:0] rom_addr;
   logic              pix_valid;
   logic [1:0]        frame_idx;
   logic [1:0]        disp_idx;
   logic              playing;
   logic              done;

   logic [1:0] exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         done_cnt;

   anim_sequencer #(
      .FRAMES(FRAMES),
      .DIV_W (DIV_W),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .ADDR_W(ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .pause     (pause),
      .restart   (restart),
      .mode      (mode),
      .vsync     (vsync),
      .ram_addr_x(ram_addr_x),
      .ram_addr_y(ram_addr_y),
      .rom_addr  (rom_addr),
      .pix_valid (pix_valid),
      .frame_idx (frame_idx),
      .disp_idx  (disp_idx),
      .playing   (playing),
      .done      (done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_restart();
      restart = 1'b1;
      step(1);
      restart = 1'b0;
   endtask

   // Run n_ticks tick periods, popping the expected index at each tick and
   // expecting exactly one done, on tick number done_at.
   task automatic run_ticks(input int n_ticks, input int done_at, input string tag);
      logic [1:0] e;
      done_cnt = 0;
      for (int k = 1; k <= n_ticks * 4; k++) begin
         step(1);
         done_cnt += int'(done);
         if (k % 4 == 0) begin
            e = exp_q.pop_front();
            check_eq({tag, "_idx"}, int'(frame_idx), int'(e));
            check_eq({tag, "_done"}, int'(done), (k == done_at * 4) ? 1 : 0);
         end
      end
      check_eq({tag, "_done_cnt"}, done_cnt, 1);
   endtask

   initial begin
      int ex;
      rst        = 1'b1;
      enable     = 1'b1;
      pause      = 1'b0;
      restart    = 1'b0;
      mode       = 2'b00;
      vsync      = 1'b1;
      ram_addr_x = 8'd0;
      ram_addr_y = 8'd0;

      #2;
      check_eq("rst_idx",   int'(frame_idx), 0);
      check_eq("rst_disp",  int'(disp_idx),  0);
      check_eq("rst_play",  int'(playing),   1);
      check_eq("rst_done",  int'(done),      0);
      check_eq("rst_addr",  int'(rom_addr),  0);
      check_eq("rst_valid", int'(pix_valid), 0);
      step(1);
      rst = 1'b0;

      // loop: 0,1,2,3,0
      exp_q = '{2'd1, 2'd2, 2'd3, 2'd0};
      run_ticks(4, 4, "loop");
      check_eq("loop_play", int'(playing), 1);

      // ping-pong: 1,2,3,2,1,0,1 ; done on 1->0
      mode  = 2'b01;
      exp_q = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
      run_ticks(7, 6, "ping");

      // one-shot: 1,2,3, then hold with playing low
      mode = 2'b10;
      pulse_restart();
      check_eq("os_rs_idx", int'(frame_idx), 0);
      exp_q = '{2'd1, 2'd2, 2'd3, 2'd3};
      run_ticks(4, 4, "os");
      check_eq("os_play", int'(playing), 0);
      mode     = 2'b00;
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step(1);
         done_cnt += int'(done);
      end
      check_eq("os_hold_idx",  int'(frame_idx), 3);
      check_eq("os_hold_play", int'(playing),   0);
      check_eq("os_hold_done", done_cnt,        0);
      pulse_restart();
      check_eq("os_re_idx",  int'(frame_idx), 0);
      check_eq("os_re_play", int'(playing),   1);
      step(3);
      check_eq("os_re_wait", int'(frame_idx), 0);
      step(1);
      check_eq("os_re_tick", int'(frame_idx), 1);

      // pause mid-period (div=2)
      step(2);
      pause    = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         step(1);
         done_cnt += int'(done);
      end
      check_eq("pause_idx",  int'(frame_idx), 1);
      check_eq("pause_done", done_cnt,        0);
      pause = 1'b0;
      step(1);
      check_eq("pause_rem1", int'(frame_idx), 1);
      step(1);
      check_eq("pause_rem2", int'(frame_idx), 2);

      // reverse loop: starts at 3, then 2,1,0,3
      mode = 2'b11;
      pulse_restart();
      check_eq("rev_rs_idx", int'(frame_idx), 3);
      exp_q = '{2'd2, 2'd1, 2'd0, 2'd3};
      run_ticks(4, 4, "rev");

      // display commit and addressing
      mode = 2'b00;
      pulse_restart();
      check_eq("vs_rs_idx", int'(frame_idx), 0);
      step(1);
      check_eq("vs_disp0", int'(disp_idx), 0);
      vsync = 1'b0;
      step(7);
      check_eq("vs_idx2",     int'(frame_idx), 2);
      check_eq("vs_disp_hold", int'(disp_idx), 0);
      vsync      = 1'b1;
      ram_addr_x = 8'd5;
      ram_addr_y = 8'd3;
      step(1);
      check_eq("vs_disp2",    int'(disp_idx), 2);
      check_eq("addr_disp0",  int'(rom_addr), 485);
      vsync = 1'b0;
      step(1);
      check_eq("addr_5_3",    int'(rom_addr),  38885);
      check_eq("valid_5_3",   int'(pix_valid), 1);
      ram_addr_x = 8'd160;
      step(1);
      check_eq("addr_x160",   int'(rom_addr),  0);
      check_eq("valid_x160",  int'(pix_valid), 0);
      ram_addr_x = 8'd159;
      ram_addr_y = 8'd119;
      step(1);
      check_eq("addr_corner", int'(rom_addr),  57599);
      check_eq("valid_corner", int'(pix_valid), 1);
      ram_addr_x = 8'd0;
      ram_addr_y = 8'd120;
      step(1);
      check_eq("addr_y120",   int'(rom_addr),  0);
      check_eq("valid_y120",  int'(pix_valid), 0);
      for (int k = 0; k < 4; k++) begin
         ram_addr_x = 8'($urandom_range(0, IMG_W - 1));
         ram_addr_y = 8'($urandom_range(0, IMG_H - 1));
         ex = 2 * IMG_W * IMG_H + int'(ram_addr_y) * IMG_W + int'(ram_addr_x);
         step(1);
         check_eq("addr_rand",  int'(rom_addr),  ex);
         check_eq("valid_rand", int'(pix_valid), 1);
      end

      // async reset while ping-pong is heading down at idx 2
      mode       = 2'b01;
      vsync      = 1'b1;
      ram_addr_x = 8'd1;
      ram_addr_y = 8'd1;
      pulse_restart();
      step(16);
      check_eq("pre_rst_idx", int'(frame_idx), 2);
      step(1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_idx",   int'(frame_idx), 0);
      check_eq("arst_disp",  int'(disp_idx),  0);
      check_eq("arst_play",  int'(playing),   1);
      check_eq("arst_done",  int'(done),      0);
      check_eq("arst_addr",  int'(rom_addr),  0);
      check_eq("arst_valid", int'(pix_valid), 0);
      step(1);
      rst  = 1'b0;
      mode = 2'b00;

      // restart coinciding with a tick: restart wins and div restarts
      step(3);
      pulse_restart();
      check_eq("rs_tick_idx",  int'(frame_idx), 0);
      check_eq("rs_tick_done", int'(done),      0);
      step(3);
      check_eq("rs_tick_wait", int'(frame_idx), 0);
      step(1);
      check_eq("rs_tick_next", int'(frame_idx), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Parametrised frame-animation player for the screen path.
- Steps a frame index at a programmable rate from a clock-enable tick; no derived clocks.
- Supports loop, ping-pong, one-shot and reverse-loop modes, plus pause and restart.
- Translates pixel coordinates into a linear sprite-ROM address for the currently displayed frame.
- Frame changes are committed only on vsync, so a frame never tears mid-scan.

Parameters:
- FRAMES, 16, number of frames in the sequence (>=1).
- DIV_W, 24, tick divider width; one frame tick every 2^DIV_W clk cycles.
- IMG_W, 160, frame width in pixels.
- IMG_H, 120, frame height in pixels.
- ADDR_W, 19, ROM address width (must hold FRAMES*IMG_W*IMG_H-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- enable  in  1  divider runs while high.
- pause  in  1  freezes divider and frame index while high.
- restart  in  1  synchronous restart of the sequence.
- mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 reverse loop.
- vsync  in  1  frame-boundary strobe; commits the sequencer frame to the display.
- ram_addr_x  in  8  pixel x.
- ram_addr_y  in  8  pixel y.
- rom_addr  out  ADDR_W  registered sprite-ROM address.
- pix_valid  out  1  registered; coordinate in range.
- frame_idx  out  $clog2(FRAMES) (min 1)  sequencer frame.
- disp_idx  out  same  frame currently used for addressing.
- playing  out  1  sequence active.
- done  out  1  one-cycle pulse at sequence completion.

Behaviour:
- Reset (async, rst=1) values:
  - div=0, frame_idx=0, disp_idx=0, dir=up, playing=1, done=0, rom_addr=0, pix_valid=0.
- Divider:
  - div increments when enable & !pause & playing.
  - tick=1 on the cycle div==all-ones; div then wraps to 0.
  - pause or !enable holds div unchanged.
- Priority, per cycle: rst > restart > tick.
- Restart:
  - div<=0, dir<=up, playing<=1, done<=0.
  - frame_idx<=FRAMES-1 if mode==11, otherwise 0.
  - disp_idx is unaffected until the next vsync.
- On tick, by mode:
  - Loop (00): idx<FRAMES-1 → idx+1; idx==FRAMES-1 → 0 with done pulse.
  - Ping-pong (01): up and idx<FRAMES-1 → idx+1; up and idx==FRAMES-1 → dir<=down, idx-1.
  - Ping-pong (01): down and idx>1 → idx-1; down and idx==1 → idx 0, dir<=up, done pulse.
  - Ping-pong endpoints are not repeated.
  - One-shot (10): idx<FRAMES-1 → idx+1; idx==FRAMES-1 → hold, playing<=0, done pulse. Exactly one done per run; restart re-arms.
  - Reverse (11): idx>0 → idx-1; idx==0 → FRAMES-1 with done pulse.
- Mode changes:
  - Take effect at the next tick.
  - dir is forced to up whenever mode!=01.
  - Switching out of one-shot while playing=0 does not resume; only restart resumes.
- FRAMES==1:
  - idx stays 0.
  - done pulses every tick in modes 00, 01 and 11.
  - One-shot ends on the first tick.
- done is registered, high for exactly one cycle, and is simultaneous with the idx update.
- Display commit:
  - disp_idx <= frame_idx on every cycle with vsync=1.
  - A tick and vsync in the same cycle commit the pre-tick frame_idx.
- Addressing (1-cycle latency, registered):
  - In range (x<IMG_W and y<IMG_H): rom_addr <= disp_idx*IMG_W*IMG_H + y*IMG_W + x, pix_valid<=1.
  - Out of range: rom_addr<=0, pix_valid<=0.
  - Arithmetic is computed at ADDR_W width with no truncation for legal parameters.

Test Plan:
- FRAMES=4, DIV_W=2, mode=00, enable=1, vsync=1 → frame_idx changes every 4 cycles: 0,1,2,3,0; done pulses once on the 3→0 update; playing stays 1.
- mode=01, same parameters → idx sequence 0,1,2,3,2,1,0,1; done pulses only on the 1→0 step.
- mode=10 → 0,1,2,3, then holds at 3; playing falls to 0 with a single done pulse; restart → idx 0, playing 1, and ticks resume after 4 cycles.
- pause=1 for 10 cycles mid-count → div and idx frozen, no done; after release, the tick arrives after the remaining cycles of the period.
- Set vsync=0, let frame_idx advance to 2, then pulse vsync → disp_idx stays 0 until the vsync cycle, then equals 2. With disp_idx=2, x=5, y=3 → next cycle rom_addr = 2*19200+3*160+5 = 38885, pix_valid=1. x=160 → rom_addr 0, pix_valid 0.
- Assert rst while mode=01 going down at idx 2 → all outputs return to reset values immediately, without waiting for clk; restart and tick on the same cycle → restart wins, idx 0.
